uart_frame_sender: RTL and testbench

//  Sits directly downstream of the board-ID/points packer. Snapshots its 32-bit word and

---
 rtl/uart_frame_sender_pkg.sv | 14 +
 rtl/uart_period_timer.sv | 31 +++
 rtl/uart_frame_sender.sv | 88 ++++++++
 tb/tb_uart_frame_sender.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_sender_pkg.sv
// Shared constants for the UART frame sender: frame layout, state encodings and checksum helper.
package uart_frame_sender_pkg;

   localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
   localparam int unsigned FRAME_LEN    = 6;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic logic [7:0] frame_chk(input logic [31:0] word);
      return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
   endfunction

endpackage

// File: rtl/uart_period_timer.sv
// Free-running period counter; tick is high for one cycle when the count reaches PERIOD_CYCLES-1.
module uart_period_timer
   import uart_frame_sender_pkg::*;
#(
   parameter int unsigned PERIOD_CYCLES = 650_000,
   parameter int unsigned CNT_W         = 20
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // A zero period disables the timer: the counter parks at 0 and never ticks.
   localparam bit             ENABLED = (PERIOD_CYCLES != 0);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ENABLED ? PERIOD_CYCLES - 1 : 0);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !ENABLED) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = ENABLED && (cnt == LAST);

endmodule

// File: rtl/uart_frame_sender.sv
// Snapshots a 32-bit word and writes it to the UART TX FIFO as SYNC, four data bytes, XOR checksum.
module uart_frame_sender
   import uart_frame_sender_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT,
   parameter int unsigned PERIOD_CYCLES = 650_000,
   parameter int unsigned CNT_W         = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tx_data_stack,
   input  logic        send_req,
   input  logic        tx_full,
   output logic        wr_uart,
   output logic [7:0]  w_data,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frames_sent
);

   logic [0:0]  state;
   logic [2:0]  idx;
   logic [31:0] snapshot;
   logic [7:0]  chk;
   logic        pending;
   logic        tick;
   logic        trigger;
   logic        last_byte;

   uart_period_timer #(
      .PERIOD_CYCLES(PERIOD_CYCLES),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   assign trigger   = send_req | tick;
   assign busy      = (state == ST_SEND);
   assign wr_uart   = busy && !tx_full;
   assign last_byte = (idx == 3'(FRAME_LEN - 1));

   always_comb begin
      w_data = SYNC_BYTE;
      case (idx)
         3'd1:    w_data = snapshot[31:24];
         3'd2:    w_data = snapshot[23:16];
         3'd3:    w_data = snapshot[15:8];
         3'd4:    w_data = snapshot[7:0];
         3'd5:    w_data = chk;
         default: w_data = SYNC_BYTE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         snapshot    <= '0;
         chk         <= '0;
         pending     <= 1'b0;
         frame_done  <= 1'b0;
         frames_sent <= '0;
      end else begin
         frame_done <= wr_uart && last_byte;
         // Pending is consumed by the IDLE->SEND transition; a trigger in that same cycle re-arms it.
         pending    <= trigger || (pending && state != ST_IDLE);
         if (state == ST_IDLE) begin
            if (pending) begin
               state    <= ST_SEND;
               snapshot <= tx_data_stack;
               chk      <= frame_chk(tx_data_stack);
               idx      <= '0;
            end
         end else if (wr_uart) begin
            if (last_byte) begin
               state       <= ST_IDLE;
               idx         <= '0;
               frames_sent <= frames_sent + 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Scoreboard bench for uart_frame_sender: stimulus queues expected bytes, negedge monitors check writes.
module tb_uart_frame_sender;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, send_req, tx_full;
   logic [31:0] tx_data_stack;
   logic        wr_uart, busy, frame_done;
   logic [7:0]  w_data;
   logic [15:0] frames_sent;

   logic        rst2;
   logic        send_req2 = 1'b0;
   logic        tx_full2  = 1'b0;
   logic [31:0] tx_data2  = 32'h0100_1234;
   logic        wr_uart2, busy2, frame_done2;
   logic [7:0]  w_data2;
   logic [15:0] frames_sent2;

   uart_frame_sender #(.PERIOD_CYCLES(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data_stack(tx_data_stack),
      .send_req     (send_req),
      .tx_full      (tx_full),
      .wr_uart      (wr_uart),
      .w_data       (w_data),
      .busy         (busy),
      .frame_done   (frame_done),
      .frames_sent  (frames_sent)
   );

   uart_frame_sender #(.PERIOD_CYCLES(20), .CNT_W(5)) dut_timer (
      .clk          (clk),
      .rst          (rst2),
      .tx_data_stack(tx_data2),
      .send_req     (send_req2),
      .tx_full      (tx_full2),
      .wr_uart      (wr_uart2),
      .w_data       (w_data2),
      .busy         (busy2),
      .frame_done   (frame_done2),
      .frames_sent  (frames_sent2)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] exp_frames = '0;
   int          done_cnt = 0;
   int          wr_seen = 0;
   int          first_wr = 0;
   int          last_wr = 0;
   int          req_cyc = 0;

   logic [7:0]  t4_bytes[6] = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h27};
   int          pos2 = 0;
   int          sync2_last = -1;
   int          syncs2 = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Main DUT monitor: every FIFO write is popped against the queue, every frame_done checks the count.
   always @(negedge clk) begin
      logic [7:0] e;
      if (wr_uart === 1'b1) begin
         chk("write_while_full", {31'b0, tx_full}, 32'h0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %02h, expected no write (cycle %0d)", w_data, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("byte", {24'b0, w_data}, {24'b0, e});
         end
         if (wr_seen == 0) first_wr = cyc;
         last_wr = cyc;
         wr_seen++;
      end
      if (frame_done === 1'b1) begin
         exp_frames++;
         done_cnt++;
         chk("frames_sent_at_done", {16'b0, frames_sent}, {16'b0, exp_frames});
      end
   end

   always @(negedge clk) begin
      if (wr_uart2 === 1'b1) begin
         chk("t4_byte", {24'b0, w_data2}, {24'b0, t4_bytes[pos2]});
         if (pos2 == 0) begin
            if (sync2_last >= 0) chk("t4_period", cyc - sync2_last, 20);
            sync2_last = cyc;
            syncs2++;
         end
         pos2 = (pos2 + 1) % 6;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [31:0] d, input logic [7:0] c);
      exp_q.push_back(8'hA5);
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      exp_q.push_back(c);
   endtask

   task automatic pulse_req();
      send_req = 1'b1;
      step(1);
      send_req = 1'b0;
   endtask

   task automatic wait_q(input int n, input string name);
      int k = 0;
      while (exp_q.size() > n && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (k >= 200) chk(name, exp_q.size(), n);
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && k < 300) begin
         @(posedge clk);
         k++;
      end
      step(2);
      if (k >= 300) chk(name, exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      rst2 = 1'b1;
      send_req = 1'b0;
      tx_full = 1'b0;
      tx_data_stack = '0;
      step(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wr_uart", {31'b0, wr_uart}, 0);
      chk("rst_w_data", {24'b0, w_data}, 32'hA5);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_frame_done", {31'b0, frame_done}, 0);
      chk("rst_frames_sent", {16'b0, frames_sent}, 0);
      step(1);

      // 1: plain frame, six back-to-back bytes, SYNC two cycles after the request edge
      wr_seen = 0;
      tx_data_stack = 32'h0100_1234;
      push_frame(32'h0100_1234, 8'h27);
      req_cyc = cyc;
      pulse_req();
      wait_done("t1_timeout");
      chk("t1_latency", first_wr - req_cyc, 2);
      chk("t1_span", last_wr - first_wr, 5);
      chk("t1_frames_sent", {16'b0, frames_sent}, 1);
      chk("t1_done_pulses", done_cnt, 1);

      // 2: three stall cycles while byte 2 is presented
      wr_seen = 0;
      push_frame(32'h0100_1234, 8'h27);
      pulse_req();
      wait_q(4, "t2_timeout_q");
      tx_full = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t2_hold_w_data", {24'b0, w_data}, 0);
         chk("t2_no_write", {31'b0, wr_uart}, 0);
      end
      @(posedge clk);
      #1;
      tx_full = 1'b0;
      wait_done("t2_timeout");
      chk("t2_span", last_wr - first_wr, 8);
      chk("t2_frames_sent", {16'b0, frames_sent}, 2);

      // 3: three requests during a frame coalesce into one frame carrying the new word
      tx_data_stack = 32'hDEAD_BEEF;
      push_frame(32'hDEAD_BEEF, 8'h22);
      pulse_req();
      wait_q(5, "t3_timeout_q");
      tx_data_stack = 32'h1234_5678;
      push_frame(32'h1234_5678, 8'h08);
      pulse_req();
      step(1);
      pulse_req();
      step(1);
      pulse_req();
      wait_done("t3_timeout");
      step(20);
      chk("t3_frames_sent", {16'b0, frames_sent}, 4);
      chk("t3_done_pulses", done_cnt, 4);
      chk("t3_idle", {31'b0, busy}, 0);

      // 4: timer-driven instance, one frame every 20 clocks
      rst2 = 1'b0;
      step(115);
      chk("t4_frames_sent", {16'b0, frames_sent2}, 5);
      chk("t4_sync_count", syncs2, 5);
      rst2 = 1'b1;

      // 5: reset while byte 3 is on the bus
      tx_data_stack = 32'hCAFE_0001;
      push_frame(32'hCAFE_0001, 8'h35);
      pulse_req();
      wait_q(3, "t5_timeout_q");
      rst = 1'b1;
      step(1);
      @(negedge clk);
      chk("t5_wr_uart", {31'b0, wr_uart}, 0);
      chk("t5_busy", {31'b0, busy}, 0);
      chk("t5_frames_sent", {16'b0, frames_sent}, 0);
      rst = 1'b0;
      exp_q.delete();
      exp_frames = '0;
      step(1);
      tx_data_stack = 32'h0100_1234;
      push_frame(32'h0100_1234, 8'h27);
      pulse_req();
      wait_done("t5_timeout");
      chk("t5_frames_after", {16'b0, frames_sent}, 1);

      // 6: counter wrap and all-ones data
      force dut.frames_sent = 16'hFFFF;
      step(1);
      release dut.frames_sent;
      exp_frames = 16'hFFFF;
      chk("t6_preload", {16'b0, frames_sent}, 32'hFFFF);
      tx_data_stack = 32'hFFFF_FFFF;
      push_frame(32'hFFFF_FFFF, 8'h00);
      pulse_req();
      wait_done("t6_timeout");
      chk("t6_wrap", {16'b0, frames_sent}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
